btn_rs_receiver: RTL and testbench

- Receiving end of the board push-button interface: takes the raw active-low BTN[1:0] lines and turns them into clean press events.
- Each button line is synchronized, debounced and edge-detected into a one-cycle press pulse.
- The pulses drive a registered RS flip-flop: BTN[0] sets, BTN[1] resets.
- Sits between the board pins and the lesson top level; presents Q/QN on LEDs and per-button press counts on two seven-segment digits.

---
 rtl/btn_rs_receiver.sv | 136 +++++++++++++
 tb/tb_btn_rs_receiver.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/btn_rs_receiver.sv
// Two active-low push buttons -> synchronized, debounced one-cycle press pulses -> registered RS flop,
// with wrapping press counters and 7-segment decode. Define RS_RESET_PRIORITY_EN to let reset win on simultaneous presses.
module btn_rs_receiver #(
  parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000,
  parameter int unsigned CNT_W           = 4
) (
  input  logic             CLK1,
  input  logic             RST_N,
  input  logic [1:0]       BTN,
  output logic             Q,
  output logic             QN,
  output logic             SET_PULSE,
  output logic             RST_PULSE,
  output logic             BOTH_ERR,
  output logic [CNT_W-1:0] SET_CNT,
  output logic [CNT_W-1:0] RST_CNT,
  output logic [7:0]       HEX0,
  output logic [7:0]       HEX1
);

  // Active-low segments g..a in bits 6..0, decimal point (bit 7) kept dark.
  function automatic logic [7:0] seg_code(input logic [3:0] v);
    case (v)
      4'h0: seg_code = 8'hC0;
      4'h1: seg_code = 8'hF9;
      4'h2: seg_code = 8'hA4;
      4'h3: seg_code = 8'hB0;
      4'h4: seg_code = 8'h99;
      4'h5: seg_code = 8'h92;
      4'h6: seg_code = 8'h82;
      4'h7: seg_code = 8'hF8;
      4'h8: seg_code = 8'h80;
      4'h9: seg_code = 8'h90;
      4'hA: seg_code = 8'h88;
      4'hB: seg_code = 8'h83;
      4'hC: seg_code = 8'hC6;
      4'hD: seg_code = 8'hA1;
      4'hE: seg_code = 8'h86;
      4'hF: seg_code = 8'h8E;
      default: seg_code = 8'hFF;
    endcase
  endfunction

  localparam logic [15:0] LAST_CNT = DEBOUNCE_CYCLES - 16'd1;

  logic [1:0]       sync1_r, sync2_r, level_r, level_d_r, level_nx_s, fall_s;
  logic [1:0][15:0] db_cnt_r, db_cnt_nx_s;
  logic             set_pulse_r, rst_pulse_r, both_err_r;
  logic             q_r, qn_r, q_nx_s;
  logic [CNT_W-1:0] set_cnt_r, rst_cnt_r;

  // Debounce: accept the synchronized level once it has differed for DEBOUNCE_CYCLES cycles in a row.
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      level_nx_s[i]  = level_r[i];
      db_cnt_nx_s[i] = 16'd0;
      if (sync2_r[i] != level_r[i]) begin
        if (db_cnt_r[i] == LAST_CNT) begin
          level_nx_s[i]  = sync2_r[i];
          db_cnt_nx_s[i] = 16'd0;
        end else begin
          db_cnt_nx_s[i] = db_cnt_r[i] + 16'd1;
        end
      end else begin
        db_cnt_nx_s[i] = 16'd0;
      end
    end
  end

  // Only presses (debounced 1->0) produce pulses; releases are ignored.
  assign fall_s = level_d_r & ~level_r;

  // RS next state from the registered pulses.
  always_comb begin
    q_nx_s = q_r;
    case ({set_pulse_r, rst_pulse_r})
      2'b10:   q_nx_s = 1'b1;
      2'b01:   q_nx_s = 1'b0;
`ifdef RS_RESET_PRIORITY_EN
      2'b11:   q_nx_s = 1'b0;
`else
      2'b11:   q_nx_s = q_r;
`endif
      default: q_nx_s = q_r;
    endcase
  end

  // Synchronizer and debounce state.
  always_ff @(posedge CLK1 or negedge RST_N) begin
    if (!RST_N) begin
      sync1_r   <= 2'b11;
      sync2_r   <= 2'b11;
      level_r   <= 2'b11;
      level_d_r <= 2'b11;
      db_cnt_r  <= {2{16'd0}};
    end else begin
      sync1_r   <= BTN;
      sync2_r   <= sync1_r;
      level_r   <= level_nx_s;
      level_d_r <= level_r;
      db_cnt_r  <= db_cnt_nx_s;
    end
  end

  // Press pulses, RS state and press counters.
  always_ff @(posedge CLK1 or negedge RST_N) begin
    if (!RST_N) begin
      set_pulse_r <= 1'b0;
      rst_pulse_r <= 1'b0;
      both_err_r  <= 1'b0;
      q_r         <= 1'b0;
      qn_r        <= 1'b1;
      set_cnt_r   <= {CNT_W{1'b0}};
      rst_cnt_r   <= {CNT_W{1'b0}};
    end else begin
      set_pulse_r <= fall_s[0];
      rst_pulse_r <= fall_s[1];
      both_err_r  <= fall_s[0] & fall_s[1];
      q_r         <= q_nx_s;
      qn_r        <= ~q_nx_s;
      set_cnt_r   <= set_cnt_r + CNT_W'(set_pulse_r);
      rst_cnt_r   <= rst_cnt_r + CNT_W'(rst_pulse_r);
    end
  end

  assign Q         = q_r;
  assign QN        = qn_r;
  assign SET_PULSE = set_pulse_r;
  assign RST_PULSE = rst_pulse_r;
  assign BOTH_ERR  = both_err_r;
  assign SET_CNT   = set_cnt_r;
  assign RST_CNT   = rst_cnt_r;
  assign HEX0      = seg_code(4'(set_cnt_r));
  assign HEX1      = seg_code(4'(rst_cnt_r));

endmodule

// File: tb/tb_btn_rs_receiver.sv
// Self-checking bench for btn_rs_receiver (DEBOUNCE_CYCLES=4) against a sample-window reference model.
module tb_btn_rs_receiver;
  localparam int D = 4;
`ifdef RS_RESET_PRIORITY_EN
  localparam bit RESET_WINS = 1'b1;
`else
  localparam bit RESET_WINS = 1'b0;
`endif

  logic       CLK1 = 1'b0;
  logic       RST_N = 1'b1;
  logic [1:0] BTN = 2'b11;
  logic       Q, QN, SET_PULSE, RST_PULSE, BOTH_ERR;
  logic [3:0] SET_CNT, RST_CNT;
  logic [7:0] HEX0, HEX1;

  btn_rs_receiver #(.DEBOUNCE_CYCLES(16'd4), .CNT_W(4)) dut (
    .CLK1(CLK1), .RST_N(RST_N), .BTN(BTN), .Q(Q), .QN(QN),
    .SET_PULSE(SET_PULSE), .RST_PULSE(RST_PULSE), .BOTH_ERR(BOTH_ERR),
    .SET_CNT(SET_CNT), .RST_CNT(RST_CNT), .HEX0(HEX0), .HEX1(HEX1)
  );

  always #5 CLK1 = ~CLK1;

  int total = 0;
  int bad = 0;
  logic [7:0] hex_tab [0:15] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                 8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

  // Reference model: a press is accepted when the last D synchronized samples all disagree with the accepted level.
  bit q_m, sp_m, rp_m, be_m;
  int sc_m, rc_m;
  bit lv [2];
  bit lvp [2];
  bit h0 [$];
  bit h1 [$];

  function automatic logic [28:0] exp_vec();
    return {q_m, ~q_m, sp_m, rp_m, be_m, 4'(sc_m), 4'(rc_m), hex_tab[sc_m], hex_tab[rc_m]};
  endfunction

  function automatic logic [28:0] obs_vec();
    return {Q, QN, SET_PULSE, RST_PULSE, BOTH_ERR, SET_CNT, RST_CNT, HEX0, HEX1};
  endfunction

  task automatic model_reset();
    q_m = 1'b0; sp_m = 1'b0; rp_m = 1'b0; be_m = 1'b0;
    sc_m = 0; rc_m = 0;
    lv[0] = 1'b1; lv[1] = 1'b1; lvp[0] = 1'b1; lvp[1] = 1'b1;
    h0.delete(); h1.delete();
    repeat (D + 2) begin h0.push_back(1'b1); h1.push_back(1'b1); end
  endtask

  task automatic model_edge();
    bit nsp, nrp, flip, smp;
    int last;
    if (!RST_N) begin
      h0.push_back(1'b1); h1.push_back(1'b1);
      void'(h0.pop_front()); void'(h1.pop_front());
      return;
    end
    h0.push_back(BTN[0]); h1.push_back(BTN[1]);
    void'(h0.pop_front()); void'(h1.pop_front());
    if (sp_m) sc_m = (sc_m + 1) % 16;
    if (rp_m) rc_m = (rc_m + 1) % 16;
    if (sp_m && rp_m) q_m = RESET_WINS ? 1'b0 : q_m;
    else if (sp_m) q_m = 1'b1;
    else if (rp_m) q_m = 1'b0;
    nsp = lvp[0] && !lv[0];
    nrp = lvp[1] && !lv[1];
    sp_m = nsp; rp_m = nrp; be_m = nsp && nrp;
    last = D + 1;
    for (int b = 0; b < 2; b++) begin
      flip = 1'b1;
      for (int j = 2; j <= D + 1; j++) begin
        smp = (b == 0) ? h0[last - j] : h1[last - j];
        if (smp == lv[b]) flip = 1'b0;
      end
      lvp[b] = lv[b];
      if (flip) lv[b] = ~lv[b];
    end
  endtask

  task automatic tick(input logic [1:0] b);
    BTN = b;
    @(posedge CLK1);
    model_edge();
    #1;
  endtask

  task automatic test_reset();
    #2 RST_N = 1'b0;
    BTN = 2'b11;
    model_reset();
    #1;
    total++;
    if (obs_vec() !== exp_vec()) begin bad++; $display("FAIL reset_async got=%h exp=%h", obs_vec(), exp_vec()); end
    repeat (3) tick(2'b11);
    RST_N = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick(2'b11);
      total++;
      if (obs_vec() !== exp_vec()) begin bad++; $display("FAIL reset_idle cyc=%0d got=%h exp=%h", i, obs_vec(), exp_vec()); end
    end
    total++;
    if ({Q, QN, HEX0, HEX1} !== {1'b0, 1'b1, 8'hC0, 8'hC0}) begin
      bad++; $display("FAIL reset_values got=%h exp=%h", {Q, QN, HEX0, HEX1}, {1'b0, 1'b1, 8'hC0, 8'hC0});
    end
  endtask

  task automatic test_glitch();
    tick(2'b11);
    BTN = 2'b10;
    #1 BTN = 2'b11;
    for (int i = 0; i < 10; i++) begin
      tick(2'b11);
      total++;
      if (obs_vec() !== exp_vec()) begin bad++; $display("FAIL glitch_sub cyc=%0d got=%h exp=%h", i, obs_vec(), exp_vec()); end
    end
    for (int i = 0; i < 15; i++) begin
      tick(i < 3 ? 2'b10 : 2'b11);
      total++;
      if (obs_vec() !== exp_vec()) begin bad++; $display("FAIL glitch_3cyc cyc=%0d got=%h exp=%h", i, obs_vec(), exp_vec()); end
    end
    total++;
    if ({Q, SET_CNT} !== 5'd0) begin bad++; $display("FAIL glitch_state got=%h exp=0", {Q, SET_CNT}); end
  endtask

  task automatic press(input int btn_idx, input string name, output int first_e, output int n_pulse);
    logic [1:0] low;
    low = (btn_idx == 0) ? 2'b10 : 2'b01;
    first_e = -1; n_pulse = 0;
    for (int e = 1; e <= 20; e++) begin
      tick(e <= 10 ? low : 2'b11);
      if (((btn_idx == 0) ? SET_PULSE : RST_PULSE) === 1'b1) begin
        n_pulse++;
        if (first_e < 0) first_e = e;
      end
      total++;
      if (obs_vec() !== exp_vec()) begin bad++; $display("FAIL %s edge=%0d got=%h exp=%h", name, e, obs_vec(), exp_vec()); end
    end
  endtask

  task automatic test_set_reset();
    int fe, np;
    press(0, "set_press", fe, np);
    total++;
    if (fe != D + 3 || np != 1) begin bad++; $display("FAIL set_latency got=%0d/%0d exp=%0d/1", fe, np, D + 3); end
    total++;
    if ({Q, SET_CNT, HEX0} !== {1'b1, 4'h1, 8'hF9}) begin bad++; $display("FAIL set_state got=%h exp=%h", {Q, SET_CNT, HEX0}, {1'b1, 4'h1, 8'hF9}); end
    press(1, "rst_press", fe, np);
    total++;
    if (fe != D + 3 || np != 1) begin bad++; $display("FAIL rst_latency got=%0d/%0d exp=%0d/1", fe, np, D + 3); end
    total++;
    if ({Q, QN, RST_CNT, HEX1} !== {1'b0, 1'b1, 4'h1, 8'hF9}) begin
      bad++; $display("FAIL rst_state got=%h exp=%h", {Q, QN, RST_CNT, HEX1}, {1'b0, 1'b1, 4'h1, 8'hF9});
    end
  endtask

  task automatic test_simultaneous();
    int fe, np, nbe;
    press(0, "sim_preset", fe, np);
    nbe = 0;
    for (int e = 1; e <= 20; e++) begin
      tick(e <= 10 ? 2'b00 : 2'b11);
      if (BOTH_ERR === 1'b1) nbe++;
      total++;
      if (obs_vec() !== exp_vec()) begin bad++; $display("FAIL simultaneous edge=%0d got=%h exp=%h", e, obs_vec(), exp_vec()); end
    end
    total++;
    if (nbe != 1 || Q !== !RESET_WINS || SET_CNT !== 4'd3 || RST_CNT !== 4'd2) begin
      bad++; $display("FAIL sim_state got=%0d,%b,%h,%h exp=1,%b,3,2", nbe, Q, SET_CNT, RST_CNT, !RESET_WINS);
    end
  endtask

  task automatic test_wrap();
    int fe, np;
    RST_N = 1'b0;
    model_reset();
    repeat (2) tick(2'b11);
    RST_N = 1'b1;
    repeat (2) tick(2'b11);
    for (int p = 1; p <= 16; p++) begin
      press(0, "wrap_press", fe, np);
      if (p == 15) begin
        total++;
        if ({SET_CNT, HEX0} !== {4'hF, 8'h8E}) begin bad++; $display("FAIL wrap_15 got=%h exp=%h", {SET_CNT, HEX0}, {4'hF, 8'h8E}); end
      end
    end
    total++;
    if ({SET_CNT, HEX0} !== {4'h0, 8'hC0}) begin bad++; $display("FAIL wrap_16 got=%h exp=%h", {SET_CNT, HEX0}, {4'h0, 8'hC0}); end
  endtask

  task automatic test_reset_mid();
    int fe;
    repeat (4) tick(2'b10);
    RST_N = 1'b0;
    model_reset();
    #1;
    total++;
    if ({Q, QN, SET_PULSE, SET_CNT, RST_CNT, HEX0} !== {1'b0, 1'b1, 1'b0, 4'h0, 4'h0, 8'hC0}) begin
      bad++; $display("FAIL midreset_async got=%h", {Q, QN, SET_PULSE, SET_CNT, RST_CNT, HEX0});
    end
    repeat (2) tick(2'b10);
    RST_N = 1'b1;
    fe = -1;
    for (int e = 1; e <= 12; e++) begin
      tick(2'b10);
      if (SET_PULSE === 1'b1 && fe < 0) fe = e;
      total++;
      if (obs_vec() !== exp_vec()) begin bad++; $display("FAIL midreset_edge edge=%0d got=%h exp=%h", e, obs_vec(), exp_vec()); end
    end
    total++;
    if (fe != D + 3 || Q !== 1'b1) begin bad++; $display("FAIL midreset_pulse got=%0d,%b exp=%0d,1", fe, Q, D + 3); end
    repeat (10) tick(2'b11);
  endtask

  task automatic test_random();
    int rem0, rem1;
    logic [1:0] b;
    b = 2'b11; rem0 = 0; rem1 = 0;
    for (int i = 0; i < 600; i++) begin
      if (rem0 == 0) begin b[0] = $urandom_range(1, 0); rem0 = $urandom_range(8, 1); end
      if (rem1 == 0) begin b[1] = $urandom_range(1, 0); rem1 = $urandom_range(8, 1); end
      rem0--; rem1--;
      tick(b);
      total++;
      if (obs_vec() !== exp_vec()) begin bad++; $display("FAIL random cyc=%0d got=%h exp=%h", i, obs_vec(), exp_vec()); end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_glitch();
    test_set_reset();
    test_simultaneous();
    test_wrap();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
